// File: rtl/cpu_l1_pkg.sv
// Shared types and constants for the bit-serial front end of the 16:1 mux.
// Optional build macro: SER_PARITY_EN adds a trailing even-parity beat.
package cpu_l1_pkg;

  localparam int SER_WORD_W = 16;
  localparam int SER_IDX_W  = 4;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } ser_state_t;
`endif

  // Even parity over a whole data word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [SER_WORD_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable bit-index counter with enable and terminal-count flag.
// DOWN=0 counts 0 -> 15, DOWN=1 counts 15 -> 0; reset lands on the start index.
module ser_bit_counter
  import cpu_l1_pkg::*;
#(
  parameter bit DOWN = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [SER_IDX_W-1:0] load_val,
  input  logic                 en,
  output logic [SER_IDX_W-1:0] count,
  output logic                 tc
);

  localparam logic [SER_IDX_W-1:0] START_IDX = DOWN ? '1 : '0;
  localparam logic [SER_IDX_W-1:0] END_IDX   = DOWN ? '0 : '1;

  logic [SER_IDX_W-1:0] count_reg;

  // Load has priority over stepping so a new word always starts cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= START_IDX;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en) begin
      if (DOWN) count_reg <= count_reg - 1'b1;
      else      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == END_IDX);

endmodule

// File: rtl/word16_serializer.sv
// Word-to-bit serializer feeding a 16:1 one-bit mux: holds the accepted word,
// walks the select index and presents the selected bit over valid/ready.
// Optional build macro: SER_PARITY_EN appends one even-parity beat per word.
module word16_serializer
  import cpu_l1_pkg::*;
#(
  parameter int MSB_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [SER_WORD_W-1:0] load_data,
  output logic [SER_WORD_W-1:0] hold_bits,
  output logic [SER_IDX_W-1:0]  sel,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_bit,
  output logic                  ser_last,
  output logic                  busy
);

  localparam logic [SER_IDX_W-1:0] START_IDX = (MSB_FIRST != 0) ? 4'd15 : 4'd0;
`ifndef SER_PARITY_EN
  // Index one step before the end; reaching it means the next beat is the last.
  localparam logic [SER_IDX_W-1:0] PRE_END_IDX = (MSB_FIRST != 0) ? 4'd1 : 4'd14;
`endif

  ser_state_t            state_reg;
  logic [SER_WORD_W-1:0] hold_reg;
  logic                  valid_reg;
  logic                  last_reg;
  logic                  busy_reg;

  logic                  accept;
  logic                  beat;
  logic                  cnt_load;
  logic                  cnt_en;
  logic                  cnt_tc;
  logic [SER_IDX_W-1:0]  sel_cnt;

  assign load_ready = (state_reg == IDLE) && !rst;
  assign accept     = load_valid && load_ready;
  assign beat       = valid_reg && ser_ready;

  // Counter control: step on every data beat except the final one, and
  // return to the start index when the word (including parity) completes.
  always_comb begin
    cnt_load = accept;
    cnt_en   = 1'b0;
    if (beat && (state_reg == SHIFT) && !cnt_tc) cnt_en = 1'b1;
`ifdef SER_PARITY_EN
    if (beat && (state_reg == PARITY)) cnt_load = 1'b1;
`else
    if (beat && (state_reg == SHIFT) && cnt_tc) cnt_load = 1'b1;
`endif
  end

  ser_bit_counter #(
    .DOWN(MSB_FIRST != 0)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(START_IDX),
    .en      (cnt_en),
    .count   (sel_cnt),
    .tc      (cnt_tc)
  );

  // Handshake FSM with registered valid/last/busy; the word is captured once
  // and left untouched until the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      hold_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            hold_reg  <= load_data;
            state_reg <= SHIFT;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
            last_reg  <= 1'b0;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (cnt_tc) begin
`ifdef SER_PARITY_EN
              state_reg <= PARITY;
              last_reg  <= 1'b1;
`else
              state_reg <= IDLE;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              last_reg  <= 1'b0;
`endif
            end else begin
`ifdef SER_PARITY_EN
              last_reg <= 1'b0;
`else
              last_reg <= (sel_cnt == PRE_END_IDX);
`endif
            end
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          if (beat) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            last_reg  <= 1'b0;
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
          last_reg  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SER_PARITY_EN
  assign ser_bit = (state_reg == PARITY) ? even_parity(hold_reg) : hold_reg[sel_cnt];
`else
  assign ser_bit = hold_reg[sel_cnt];
`endif

  assign hold_bits = hold_reg;
  assign sel       = sel_cnt;
  assign ser_valid = valid_reg;
  assign ser_last  = last_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_word16_serializer.sv
// Self-checking bench for word16_serializer: one LSB-first and one MSB-first
// instance, directed words from the test plan plus random words with random
// backpressure, checked against a per-word expected beat list.
module tb_word16_serializer;

`ifdef SER_PARITY_EN
  localparam int NBEATS = 17;
`else
  localparam int NBEATS = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        load_valid [2];
  logic        load_ready [2];
  logic [15:0] load_data  [2];
  logic [15:0] hold_bits  [2];
  logic [3:0]  sel        [2];
  logic        ser_valid  [2];
  logic        ser_ready  [2];
  logic        ser_bit    [2];
  logic        ser_last   [2];
  logic        busy       [2];

  word16_serializer #(.MSB_FIRST(0)) dut0 (
    .clk(clk), .rst(rst[0]), .load_valid(load_valid[0]), .load_ready(load_ready[0]),
    .load_data(load_data[0]), .hold_bits(hold_bits[0]), .sel(sel[0]),
    .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]), .ser_bit(ser_bit[0]),
    .ser_last(ser_last[0]), .busy(busy[0])
  );

  word16_serializer #(.MSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst[1]), .load_valid(load_valid[1]), .load_ready(load_ready[1]),
    .load_data(load_data[1]), .hold_bits(hold_bits[1]), .sel(sel[1]),
    .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]), .ser_bit(ser_bit[1]),
    .ser_last(ser_last[1]), .busy(busy[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the reset values of one instance (outputs sampled while/after reset).
  task automatic chk_reset_vals(input int d, input logic exp_ready);
    chk($sformatf("rst_hold%0d", d),  hold_bits[d], 16'h0);
    chk($sformatf("rst_sel%0d", d),   sel[d], (d == 1) ? 4'd15 : 4'd0);
    chk($sformatf("rst_valid%0d", d), ser_valid[d], 1'b0);
    chk($sformatf("rst_last%0d", d),  ser_last[d], 1'b0);
    chk($sformatf("rst_busy%0d", d),  busy[d], 1'b0);
    chk($sformatf("rst_lrdy%0d", d),  load_ready[d], exp_ready);
  endtask

  // Send one word to instance d. Entered and left on a falling edge.
  // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
  // keep: leave load_valid high and present nxt as the final beat goes out.
  // abort_at: stop (without finishing) once this many beats have completed.
  task automatic send_word(input int d, input logic [15:0] w, input int mode,
                           input bit keep, input logic [15:0] nxt, input int abort_at);
    logic       exp_bit [$];
    logic [3:0] exp_sel [$];
    int n = 0;
    int beat = 0;
    int cyc = 1;
    int k = 0;
    bit rdy;
    // Expected stream: bit order from the direction, then optional parity.
    for (int i = 0; i < 16; i++) begin
      automatic int pos = (d == 1) ? 15 - i : i;
      exp_bit.push_back(w[pos]);
      exp_sel.push_back(4'(pos));
    end
`ifdef SER_PARITY_EN
    exp_bit.push_back(($countones(w) % 2) == 1);
    exp_sel.push_back((d == 1) ? 4'd0 : 4'd15);
`endif
    while (!load_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", load_ready[d], 1'b1);
    load_valid[d] = 1'b1;
    load_data[d]  = w;
    @(negedge clk);
    if (!keep) load_valid[d] = 1'b0;
    load_data[d] = 16'($urandom);
    while (beat < NBEATS && cyc < 300) begin
      if (beat == abort_at) break;
      chk("valid",  ser_valid[d], 1'b1);
      chk("busy",   busy[d], 1'b1);
      chk("lrdy_busy", load_ready[d], 1'b0);
      chk("hold",   hold_bits[d], w);
      chk($sformatf("sel_b%0d", beat),  sel[d], exp_sel[beat]);
      chk($sformatf("bit_b%0d", beat),  ser_bit[d], exp_bit[beat]);
      chk($sformatf("last_b%0d", beat), ser_last[d], (beat == NBEATS - 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 4) == 0) || ((k % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ser_ready[d] = rdy;
      if (rdy) begin
        beat++;
        if (keep && beat == NBEATS) load_data[d] = nxt;
      end
      k++;
      @(negedge clk);
      cyc++;
    end
    if (beat == abort_at) begin
      $display("word inst=%0d data=%h aborted after %0d beats", d, w, beat);
      return;
    end
    chk("beats_done", beat, NBEATS);
    chk("end_valid", ser_valid[d], 1'b0);
    chk("end_busy",  busy[d], 1'b0);
    chk("end_last",  ser_last[d], 1'b0);
    chk("end_lrdy",  load_ready[d], 1'b1);
    if (mode == 0) chk("word_cycles", cyc, NBEATS + 1);
    $display("word inst=%0d data=%h beats=%0d cycles=%0d", d, w, beat, cyc);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      load_valid[d] = 1'b0;
      load_data[d] = 16'h0;
      ser_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset_vals(0, 1'b0);
    chk_reset_vals(1, 1'b0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("lrdy_after_rst0", load_ready[0], 1'b1);
    chk("lrdy_after_rst1", load_ready[1], 1'b1);

    // Directed words from the test plan.
    send_word(0, 16'hA5C3, 0, 1'b0, 16'h0, -1);
    send_word(1, 16'hA5C3, 0, 1'b0, 16'h0, -1);
    send_word(0, 16'hFFFF, 1, 1'b0, 16'h0, -1);
    send_word(1, 16'hFFFF, 1, 1'b0, 16'h0, -1);
    send_word(0, 16'h0001, 0, 1'b1, 16'h8000, -1);
    send_word(0, 16'h8000, 0, 1'b0, 16'h0, -1);

    // Abort mid-word with reset, then recover.
    send_word(0, 16'h1234, 0, 1'b0, 16'h0, 7);
    rst[0] = 1'b1;
    @(negedge clk);
    chk_reset_vals(0, 1'b0);
    rst[0] = 1'b0;
    ser_ready[0] = 1'b1;
    @(negedge clk);
    chk_reset_vals(0, 1'b1);
    send_word(0, 16'h0F0F, 0, 1'b0, 16'h0, -1);

    // Parity-relevant words, back to back.
    send_word(0, 16'h0007, 0, 1'b1, 16'h0003, -1);
    send_word(0, 16'h0003, 0, 1'b0, 16'h0, -1);

    // Random words with random backpressure on both directions.
    for (int i = 0; i < 8; i++) begin
      send_word(i % 2, 16'($urandom), 2, 1'b0, 16'h0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
